coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
Upstream front end of the vending machine FSM. Takes raw 5 rs and 10 rs coin-slot sensor lines, synchronises and debounces them, and classifies each insertion into the machine's 2-bit coin code (01 = 5 rs, 10 = 10 rs). Coins are queued in a small FIFO and released one per cycle under a ready/valid handshake. Jams and overflow are flagged as rejects.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a sensor must hold a level to be accepted (range 2..15)
FIFO_DEPTH, 4, coin queue entries (power of two, range 2..16)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
sense_5  input  1  raw 5 rs slot sensor, asynchronous, may glitch
sense_10  input  1  raw 10 rs slot sensor, asynchronous, may glitch
coin_ready  input  1  downstream accepts coin this cycle
coin  output  2  head coin code; 2'b00 whenever coin_valid=0
coin_valid  output  1  FIFO non-empty
reject  output  1  one-cycle pulse: coin discarded (jam or overflow)
fifo_full  output  1  occupancy == FIFO_DEPTH
coin_count  output  $clog2(FIFO_DEPTH+1)  current occupancy

Behaviour:
- Clocking: single clock clk. Reset rst is synchronous and active-high.
- Reset (sampled high at a posedge):
  - sync flops cleared; both debounce FSMs to IDLE; counters 0; FIFO emptied.
  - coin=00, coin_valid=0, reject=0, fifo_full=0, coin_count=0.
  - Reset mid-operation discards queued coins and any in-progress qualification.
- Synchroniser: 2-flop synchroniser per sensor. Downstream logic uses only the synchronised signal s.
- Debounce FSM per sensor, with a counter cnt:
  - IDLE: s=1 -> QUAL_HI, cnt=1.
  - QUAL_HI: s=1 -> cnt++; when cnt reaches DEBOUNCE_CYCLES -> HELD and emit a one-cycle event. s=0 -> IDLE (glitch, no event).
  - HELD: s=0 -> QUAL_LO, cnt=1.
  - QUAL_LO: s=0 -> cnt++; at DEBOUNCE_CYCLES -> IDLE. s=1 -> HELD (bounce, no new event).
  - Exactly one event per debounced insertion, however long the sensor is held.
- Classification, on event cycle E:
  - Only ev_5 -> push 01.
  - Only ev_10 -> push 10.
  - ev_5 and ev_10 in the same cycle -> jam: no push, reject=1 for one cycle.
  - Event while fifo_full=1 (registered value, before any same-cycle pop) -> no push, reject=1. A pop in the same cycle does not rescue the coin.
- Latency: counting the first posedge that samples a sense line high as edge 1, coin_valid is high after edge DEBOUNCE_CYCLES+3 when the FIFO was empty (after edge 7 at the default).
- FIFO:
  - Circular buffer with read/write pointers wrapping at FIFO_DEPTH; coin_count tracks occupancy.
  - Pop when coin_valid && coin_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pop on empty is ignored.
  - coin is combinational from the head entry, masked to 00 when empty.
  - Strict FIFO ordering of accepted coins.
- Handshake: coin/coin_valid must stay stable while coin_valid=1 && coin_ready=0. The vending machine top level ties coin_ready=1, so it sees each coin for exactly one cycle and 00 on idle cycles.
- Both sensors debounce independently. A 10 rs event arriving while 5 rs is HELD is accepted normally.

Decomposition:
- Shared package vm_pkg:
  - typedef logic [1:0] coin_t
  - constants COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10
  - debounce state enum {IDLE, QUAL_HI, HELD, QUAL_LO}
- Sub-module coin_debounce: synchroniser, FSM and counter, parameterised by DEBOUNCE_CYCLES, output event. Instantiated twice.
- FIFO and classification stay inline in coin_acceptor.

Test Plan:
- Reset check: rst high for 2 cycles while sense_5 is held high -> all outputs 0, no coin after release until a fresh qualification completes.
- Clean 5 rs coin: sense_5 high for 10 cycles, coin_ready=1 -> coin=01, coin_valid=1 for exactly one cycle after edge 7, reject=0.
- Glitch and bounce: sense_10 high for 3 cycles then low, then a 1-cycle low dip inside a 12-cycle high pulse -> exactly one coin=10; the 3-cycle glitch produces nothing.
- Jam: sense_5 and sense_10 rise on the same edge and both held 8 cycles -> reject pulses once, coin_count stays 0.
- Overflow: coin_ready=0 with 5 alternating coins (5,10,5,10,5) -> coin_count=4, fifo_full=1, reject on the 5th; then coin_ready=1 drains 01,10,01,10 in order.
- Simultaneous push/pop: occupancy 2, coin_ready=1, new coin event on the same cycle -> coin_count remains 2, order preserved. Reset asserted mid-queue -> count=0 on the next cycle.

Source files
------------

// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared coin codes and debounce state type for the vending machine front end
package vm_pkg;

   typedef logic [1:0] coin_t;

   localparam coin_t COIN_NONE = 2'b00;
   localparam coin_t COIN_5    = 2'b01;
   localparam coin_t COIN_10   = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      QUAL_HI,
      HELD,
      QUAL_LO
   } deb_state_e;

endpackage

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - two-flop synchroniser plus debounce FSM, one event per qualified insertion
module coin_debounce
   import vm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic sense_i,
   output logic event_o
);

   localparam logic [3:0] LAST = 4'(DEBOUNCE_CYCLES);

   logic       sync1_q, sync2_q;
   deb_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       ev_q, ev_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         ev_q    <= 1'b0;
      end else begin
         sync1_q <= sense_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ev_q    <= ev_d;
      end
   end

   // cnt counts samples already held; the sample that reaches LAST completes qualification
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ev_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync2_q) begin
               state_d = QUAL_HI;
               cnt_d   = 4'd1;
            end
         end
         QUAL_HI: begin
            if (!sync2_q) begin
               state_d = IDLE;
            end else if (cnt_q + 4'd1 == LAST) begin
               state_d = HELD;
               ev_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HELD: begin
            if (!sync2_q) begin
               state_d = QUAL_LO;
               cnt_d   = 4'd1;
            end
         end
         QUAL_LO: begin
            if (sync2_q) begin
               state_d = HELD;
            end else if (cnt_q + 4'd1 == LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign event_o = ev_q;

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced coin classification into a ready/valid coin queue with reject flag
module coin_acceptor
   import vm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               sense_5,
   input  logic                               sense_10,
   input  logic                               coin_ready,
   output logic [1:0]                         coin,
   output logic                               coin_valid,
   output logic                               reject,
   output logic                               fifo_full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    coin_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   coin_t         mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          ev_5, ev_10, one_ev, push, pop;
   coin_t         push_coin;

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_5 (
      .clk     (clk),
      .rst     (rst),
      .sense_i (sense_5),
      .event_o (ev_5)
   );

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_10 (
      .clk     (clk),
      .rst     (rst),
      .sense_i (sense_10),
      .event_o (ev_10)
   );

   // Full is judged on the registered occupancy, so a same-cycle pop cannot make room
   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign coin_valid = (count_q != '0);
   assign one_ev     = ev_5 ^ ev_10;
   assign push       = one_ev && !fifo_full;
   assign pop        = coin_valid && coin_ready;
   assign reject     = (ev_5 && ev_10) || (one_ev && fifo_full);
   assign push_coin  = ev_5 ? COIN_5 : COIN_10;
   assign coin       = coin_valid ? mem_q[rd_ptr_q] : COIN_NONE;
   assign coin_count = count_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= push_coin;
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed bench for coin_acceptor with a run-length debounce and queue model
module tb_coin_acceptor;

   localparam int D     = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sense_5 = 1'b0;
   logic          sense_10 = 1'b0;
   logic          coin_ready = 1'b0;
   logic [1:0]    coin;
   logic          coin_valid;
   logic          reject;
   logic          fifo_full;
   logic [CW-1:0] coin_count;

   int total = 0;
   int bad   = 0;
   int rej_cnt = 0;
   logic [1:0] popped[$];

   always #5 clk = ~clk;

   coin_acceptor #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .sense_5    (sense_5),
      .sense_10   (sense_10),
      .coin_ready (coin_ready),
      .coin       (coin),
      .coin_valid (coin_valid),
      .reject     (reject),
      .fifo_full  (fifo_full),
      .coin_count (coin_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] getp(input int i);
      if (i < popped.size()) return popped[i];
      return 2'bxx;
   endfunction

   // Model: a sensor's accepted level flips after D consecutive sampled cycles at the other level
   logic [1:0] m_q[$];
   bit         m_ok = 1'b0;
   bit         d1[2], d2[2], lvl[2], ev[2];
   int         run[2];

   always @(posedge clk) begin
      bit sv[2];
      bit full_pre;
      sv[0] = sense_5;
      sv[1] = sense_10;
      if (rst) begin
         m_q.delete();
         for (int k = 0; k < 2; k++) begin
            d1[k] = 0; d2[k] = 0; lvl[k] = 0; ev[k] = 0; run[k] = 0;
         end
         m_ok = 1'b1;
      end else begin
         full_pre = (m_q.size() == DEPTH);
         if (m_q.size() > 0 && coin_ready) void'(m_q.pop_front());
         if (ev[0] != ev[1] && !full_pre) m_q.push_back(ev[0] ? 2'b01 : 2'b10);
         for (int k = 0; k < 2; k++) begin
            ev[k] = 0;
            if (d2[k] != lvl[k]) begin
               run[k]++;
               if (run[k] == D) begin
                  lvl[k] = d2[k];
                  run[k] = 0;
                  ev[k]  = d2[k];
               end
            end else begin
               run[k] = 0;
            end
            d2[k] = d1[k];
            d1[k] = sv[k];
         end
      end
   end

   always @(negedge clk) begin
      int sz;
      logic [1:0] hc;
      if (m_ok) begin
         sz = m_q.size();
         hc = (sz > 0) ? m_q[0] : 2'b00;
         check("coin", coin, hc);
         check("coin_valid", coin_valid, sz > 0);
         check("fifo_full", fifo_full, sz == DEPTH);
         check("coin_count", coin_count, sz);
         check("reject", reject, (ev[0] && ev[1]) || ((ev[0] ^ ev[1]) && sz == DEPTH));
         if (reject) rej_cnt++;
         if (coin_valid && coin_ready) popped.push_back(coin);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int r0;

      // Reset held with sense_5 high
      rst = 1'b1; sense_5 = 1'b1;
      step(2);
      check("rst_coin", coin, 2'b00);
      check("rst_valid", coin_valid, 1'b0);
      check("rst_reject", reject, 1'b0);
      check("rst_full", fifo_full, 1'b0);
      check("rst_count", coin_count, 0);
      rst = 1'b0;
      step(6);
      check("post_rst_early", coin_valid, 1'b0);
      step(1);
      check("post_rst_valid", coin_valid, 1'b1);
      check("post_rst_coin", coin, 2'b01);
      sense_5 = 1'b0; coin_ready = 1'b1;
      step(1);
      check("post_rst_drained", coin_count, 0);
      step(10);

      // Clean 5 rs coin, ready tied high
      p0 = popped.size();
      sense_5 = 1'b1;
      step(6);
      check("clean_lat_edge6", coin_valid, 1'b0);
      step(1);
      check("clean_lat_edge7", coin_valid, 1'b1);
      check("clean_coin", coin, 2'b01);
      check("clean_reject", reject, 1'b0);
      step(1);
      check("clean_one_cycle", coin_valid, 1'b0);
      step(2);
      sense_5 = 1'b0;
      step(10);
      check("clean_pop_count", popped.size() - p0, 1);

      // Short glitch, then a long pulse with a one-cycle dip
      p0 = popped.size();
      sense_10 = 1'b1; step(3);
      sense_10 = 1'b0; step(8);
      check("glitch_none", popped.size() - p0, 0);
      sense_10 = 1'b1; step(5);
      sense_10 = 1'b0; step(1);
      sense_10 = 1'b1; step(6);
      sense_10 = 1'b0; step(10);
      check("bounce_one", popped.size() - p0, 1);
      check("bounce_code", getp(p0), 2'b10);

      // Jam: both sensors together
      p0 = popped.size(); r0 = rej_cnt;
      sense_5 = 1'b1; sense_10 = 1'b1; step(8);
      sense_5 = 1'b0; sense_10 = 1'b0; step(10);
      check("jam_reject", rej_cnt - r0, 1);
      check("jam_count", coin_count, 0);
      check("jam_no_coin", popped.size() - p0, 0);

      // Overflow with downstream stalled
      coin_ready = 1'b0; r0 = rej_cnt;
      for (int i = 0; i < 5; i++) begin
         if (i % 2 == 0) sense_5 = 1'b1; else sense_10 = 1'b1;
         step(6);
         sense_5 = 1'b0; sense_10 = 1'b0;
         step(7);
      end
      check("ovf_count", coin_count, 4);
      check("ovf_full", fifo_full, 1'b1);
      check("ovf_reject", rej_cnt - r0, 1);
      check("ovf_stall_head", coin, 2'b01);
      p0 = popped.size();
      coin_ready = 1'b1;
      step(5);
      check("ovf_drained", coin_count, 0);
      check("ovf_order0", getp(p0), 2'b01);
      check("ovf_order1", getp(p0 + 1), 2'b10);
      check("ovf_order2", getp(p0 + 2), 2'b01);
      check("ovf_order3", getp(p0 + 3), 2'b10);

      // Push and pop in the same cycle, then reset mid-queue
      coin_ready = 1'b0;
      sense_5 = 1'b1; step(6); sense_5 = 1'b0; step(7);
      sense_10 = 1'b1; step(6); sense_10 = 1'b0; step(7);
      check("pp_pre_count", coin_count, 2);
      sense_10 = 1'b1;
      step(6);
      check("pp_ev_count", coin_count, 2);
      p0 = popped.size();
      coin_ready = 1'b1;
      step(1);
      coin_ready = 1'b0;
      check("pp_count_same", coin_count, 2);
      check("pp_popped_first", getp(p0), 2'b01);
      check("pp_new_head", coin, 2'b10);
      rst = 1'b1;
      step(1);
      check("midq_rst_count", coin_count, 0);
      check("midq_rst_valid", coin_valid, 1'b0);
      rst = 1'b0; sense_10 = 1'b0;
      step(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
